// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/write-back, 2-5 cycles per instruction.
// Stalls in FETCH, MEMRD and MEMWR until mem_ready_i; outputs are combinational from state and are forced low during reset.
module mips_multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [5:0]       opcode_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             pc_write_cond_o,
   output logic             i_or_d_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             ir_write_o,
   output logic             mem_to_reg_o,
   output logic             reg_dst_o,
   output logic             reg_write_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic [1:0]       pc_source_o,
   output logic             illegal_op_o,
   output logic             instr_done_o,
   output logic [CNT_W-1:0] retired_o,
   output logic [3:0]       state_o
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_dst_o       = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      alu_op_o        = 2'b00;
      pc_source_o     = 2'b00;
      illegal_op_o    = 1'b0;
      instr_done_o    = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
            if (mem_ready_i) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b_o = 2'b11;
            case (opcode_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  illegal_op_o = 1'b1;
                  state_d      = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
            if (mem_ready_i) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            mem_write_o = 1'b1;
            i_or_d_o    = 1'b1;
            if (mem_ready_i) begin
               instr_done_o = 1'b1;
               state_d      = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 2'b10;
            state_d     = S_RWB;
         end
         S_RWB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 1'b1;
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = 2'b01;
            pc_write_cond_o = 1'b1;
            pc_source_o     = 2'b01;
            instr_done_o    = 1'b1;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            pc_write_o   = 1'b1;
            pc_source_o  = 2'b10;
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset has priority over every strobe, including the mem_ready-gated ones.
      if (!rst_n_i) begin
         pc_write_o      = 1'b0;
         pc_write_cond_o = 1'b0;
         i_or_d_o        = 1'b0;
         mem_read_o      = 1'b0;
         mem_write_o     = 1'b0;
         ir_write_o      = 1'b0;
         mem_to_reg_o    = 1'b0;
         reg_dst_o       = 1'b0;
         reg_write_o     = 1'b0;
         alu_src_a_o     = 1'b0;
         alu_src_b_o     = 2'b00;
         alu_op_o        = 2'b00;
         pc_source_o     = 2'b00;
         illegal_op_o    = 1'b0;
         instr_done_o    = 1'b0;
      end
      retired_d = retired_q + CNT_W'(instr_done_o);
   end

   assign retired_o = retired_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: path-table reference model, per-cycle compare, directed latency/sequence checks, random traffic.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mr = 1'b0;

   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [31:0] retired;
   logic [3:0]  state;

   logic       d4_pc_write, d4_pc_write_cond, d4_i_or_d, d4_mem_read, d4_mem_write, d4_ir_write;
   logic       d4_mem_to_reg, d4_reg_dst, d4_reg_write, d4_alu_src_a, d4_illegal_op, d4_instr_done;
   logic [1:0] d4_alu_src_b, d4_alu_op, d4_pc_source;
   logic [3:0] d4_retired;
   logic [3:0] d4_state;

   int  tests = 0;
   int  fails = 0;
   bit  cmp_en = 1'b0;
   int  mw_cnt;

   int          m_cur = 0;
   int          m_k = 0;
   logic [5:0]  m_op = 6'd0;
   logic [31:0] m_cnt = 32'd0;

   always #5 clk = ~clk;

   mips_multicycle_control #(.CNT_W(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .mem_ready_i(mr),
      .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .i_or_d_o(i_or_d),
      .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
      .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst), .reg_write_o(reg_write),
      .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
      .pc_source_o(pc_source), .illegal_op_o(illegal_op), .instr_done_o(instr_done),
      .retired_o(retired), .state_o(state));

   mips_multicycle_control #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .mem_ready_i(mr),
      .pc_write_o(d4_pc_write), .pc_write_cond_o(d4_pc_write_cond), .i_or_d_o(d4_i_or_d),
      .mem_read_o(d4_mem_read), .mem_write_o(d4_mem_write), .ir_write_o(d4_ir_write),
      .mem_to_reg_o(d4_mem_to_reg), .reg_dst_o(d4_reg_dst), .reg_write_o(d4_reg_write),
      .alu_src_a_o(d4_alu_src_a), .alu_src_b_o(d4_alu_src_b), .alu_op_o(d4_alu_op),
      .pc_source_o(d4_pc_source), .illegal_op_o(d4_illegal_op), .instr_done_o(d4_instr_done),
      .retired_o(d4_retired), .state_o(d4_state));

   wire [15:0] act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
   wire [15:0] d4_ctrl  = {d4_pc_write, d4_pc_write_cond, d4_i_or_d, d4_mem_read, d4_mem_write,
                           d4_ir_write, d4_mem_to_reg, d4_reg_dst, d4_reg_write, d4_alu_src_a,
                           d4_alu_src_b, d4_alu_op, d4_pc_source};

   // Steps after DECODE for each opcode; -1 ends the instruction, an empty path means illegal.
   function automatic int pstep(input logic [5:0] op, input int k);
      int p[4];
      p = '{-1, -1, -1, -1};
      case (op)
         6'd0:  p = '{6, 7, -1, -1};
         6'd35: p = '{2, 3, 4, -1};
         6'd43: p = '{2, 5, -1, -1};
         6'd4:  p = '{8, -1, -1, -1};
         6'd2:  p = '{9, -1, -1, -1};
         6'd8:  p = '{10, 11, -1, -1};
         default: ;
      endcase
      return (k >= 0 && k < 4) ? p[k] : -1;
   endfunction

   function automatic bit waits(input int s);
      return (s == 0) || (s == 3) || (s == 5);
   endfunction

   function automatic logic [15:0] ctrl_of(input int s, input logic rdy);
      logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (s)
         0:  begin mrd = 1; asb = 2'b01; irw = rdy; pw = rdy; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iod = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         9:  begin pw = 1; psrc = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cur = 0;
         m_cnt = 32'd0;
      end else if (m_cur == 0) begin
         if (mr) m_cur = 1;
      end else if (m_cur == 1) begin
         m_op = opcode;
         m_k  = 0;
         m_cur = (pstep(opcode, 0) < 0) ? 0 : pstep(opcode, 0);
      end else if (waits(m_cur) && !mr) begin
         m_cur = m_cur;
      end else if (pstep(m_op, m_k + 1) < 0) begin
         m_cnt = m_cnt + 32'd1;
         m_cur = 0;
      end else begin
         m_k   = m_k + 1;
         m_cur = pstep(m_op, m_k);
      end
   end

   always @(negedge clk) begin
      logic [15:0] e_ctrl;
      logic        e_ill, e_done;
      if (cmp_en) begin
         e_ctrl = rst_n ? ctrl_of(m_cur, mr) : 16'h0;
         e_ill  = rst_n && (m_cur == 1) && (pstep(opcode, 0) < 0);
         e_done = rst_n && (m_cur > 1) && (pstep(m_op, m_k + 1) < 0) && !(waits(m_cur) && !mr);
         chk("ctrl", 64'(act_ctrl), 64'(e_ctrl));
         chk("flags", 64'({illegal_op, instr_done}), 64'({e_ill, e_done}));
         chk("state", 64'(state), 64'(m_cur));
         chk("retired", 64'(retired), 64'(m_cnt));
         chk("ctrl4", 64'(d4_ctrl), 64'(e_ctrl));
         chk("retired4", 64'(d4_retired), 64'(m_cnt[3:0]));
      end
   end

   task automatic step(input logic r, input logic rdy, input logic [5:0] op);
      @(posedge clk);
      #1;
      rst_n = r; mr = rdy; opcode = op;
      @(negedge clk);
   endtask

   // Runs one instruction from FETCH; mask bit c drops mem_ready in cycle c.
   task automatic run(input logic [5:0] op, input int mask, input int exp_n,
                      input logic [31:0] exp_seq, input logic [31:0] exp_ret, input string name);
      int n = 0;
      bit got = 0;
      logic [31:0] seq = 32'd0;
      mw_cnt = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         step(1'b1, !mask[c], op);
         if (c == 0) chk({name, "_ret"}, 64'(retired), 64'(exp_ret));
         n++;
         seq = {seq[27:0], state};
         if (mem_write) mw_cnt++;
         if (instr_done || illegal_op) got = 1;
      end
      chk({name, "_cycles"}, 64'(n), 64'(exp_n));
      chk({name, "_seq"}, 64'(seq), 64'(exp_seq));
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(1'b0, 1'b0, 6'd0);
      cmp_en = 1'b1;
      step(1'b0, 1'b1, 6'd0);
      chk("rst_ctrl", 64'(act_ctrl), 64'h0);
      chk("rst_state", 64'(state), 64'h0);
      chk("rst_retired", 64'(retired), 64'h0);
      step(1'b1, 1'b0, 6'd35);
      chk("first_fetch", 64'(act_ctrl), 64'h1010);
      step(1'b1, 1'b1, 6'd35);
      step(1'b1, 1'b1, 6'd35);
      step(1'b1, 1'b1, 6'd35);
      chk("lw_memadr", 64'(state), 64'd2);
      step(1'b0, 1'b0, 6'd35);
      chk("rst_memrd_ctrl", 64'(act_ctrl), 64'h0);
      step(1'b1, 1'b0, 6'd35);
      chk("rst_abandon_state", 64'(state), 64'd0);
      chk("rst_abandon_ret", 64'(retired), 64'd0);

      for (int i = 0; i < 16; i++) run(6'd2, 0, 3, 32'h019, 32'(i), "j_wrap");
      step(1'b1, 1'b0, 6'd0);
      chk("wrap4", 64'(d4_retired), 64'd0);
      chk("wrap32", 64'(retired), 64'd16);

      run(6'd0, 0, 4, 32'h0167, 32'd16, "rtype");
      run(6'd0, 1, 5, 32'h00167, 32'd17, "rtype_fstall");
      run(6'd35, 24, 7, 32'h0123334, 32'd18, "lw_stall");
      run(6'd43, 0, 4, 32'h0125, 32'd19, "sw");
      chk("sw_mw", 64'(mw_cnt), 64'd1);
      run(6'd43, 8, 5, 32'h01255, 32'd20, "sw_stall");
      chk("sw_stall_mw", 64'(mw_cnt), 64'd2);
      run(6'd4, 0, 3, 32'h018, 32'd21, "beq");
      run(6'd2, 0, 3, 32'h019, 32'd22, "j");
      run(6'd63, 0, 2, 32'h01, 32'd23, "illegal");
      run(6'd8, 0, 4, 32'h01AB, 32'd23, "addi");
      step(1'b1, 1'b0, 6'd0);
      chk("ret_final", 64'(retired), 64'd24);

      begin
         logic [5:0] ops [6];
         logic [5:0] cur_op;
         int r;
         ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
         cur_op = 6'd0;
         for (int c = 0; c < 4000; c++) begin
            if (m_cur == 0) begin
               r = $urandom_range(0, 7);
               cur_op = (r < 6) ? ops[r] : 6'($urandom_range(0, 63));
            end
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), cur_op);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS datapath: a Moore state machine that decodes the 6-bit opcode and sequences fetch, decode, execute, memory and write-back steps. It is the producer of the 2-bit ALUOp consumed by ALU control. ALUOp 00 selects add, 01 selects subtract, and 10 selects decode from funct. The block also drives every datapath enable and mux select, and waits on a memory-ready handshake during memory accesses.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- retired  out  CNT_W  count of completed instructions.
- state  out  4  current state, for debug.

## Operation
- States, with their 4-bit codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Any output not listed for a state below is 0.
- FETCH:
  - Always drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Moves to DECODE on mem_ready=1; otherwise stays in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw → MEMADR, R-type → EXEC, beq → BRANCH, j → JUMP, addi → ADDIEX.
  - Any other opcode: illegal_op=1 for this cycle and next state is FETCH. No retire.
- MEMADR: drives alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: drives mem_read=1, i_or_d=1. Moves to MEMWB on mem_ready=1; otherwise holds.
- MEMWB: drives reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH; done.
- MEMWR:
  - Drives mem_write=1, i_or_d=1.
  - When mem_ready=1: done and next state FETCH. Otherwise holds with mem_write still asserted.
- EXEC: drives alu_src_a=1, alu_src_b=00, alu_op=10. Next state RWB.
- RWB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH; done.
- BRANCH: drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH; done.
- JUMP: drives pc_write=1, pc_source=10. Next state FETCH; done.
- ADDIEX: drives alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH; done.
- "done" means instr_done=1 and retired increments by 1 at the clock edge ending that cycle.
- retired wraps modulo 2^CNT_W.
- Outputs are combinational from state, plus the mem_ready gating in FETCH and MEMWR. No output depends on opcode except illegal_op.

## Timing
- Reset:
  - rst_n sampled low at a rising edge: state=FETCH and retired=0 after that edge.
  - While rst_n is low, all control outputs, illegal_op and instr_done are forced to 0.
  - Reset mid-instruction abandons the instruction with no retire.
  - First fetch request is issued in the first cycle with rst_n high.
- Latency with mem_ready held at 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3; illegal opcode 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. All outputs stay stable during the stall.
- mem_ready is ignored in every other state.
- opcode is sampled only in DECODE and MEMADR. It must be held stable from the cycle after a FETCH with ir_write until the next FETCH.

## Test plan
- Reset: rst_n=0 for 2 cycles, then release → state=0, retired=0, all outputs 0 during reset. The first cycle after release has mem_read=1, alu_src_b=01.
- R-type 000000, mem_ready=1 → states 0,1,6,7. alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in RWB; retired=1.
- lw then sw, with mem_ready low for 2 cycles in MEMRD:
  - lw takes 7 cycles; mem_to_reg=1 in MEMWB.
  - sw takes 4 cycles; mem_write=1 for exactly 1 cycle.
  - retired=2.
- beq 000100 → BRANCH asserts alu_op=01, pc_write_cond=1, pc_source=01. j 000010 → JUMP asserts pc_write=1, pc_source=10. Each takes 3 cycles.
- Illegal opcode 111111 → illegal_op pulses in DECODE, return to FETCH, retired unchanged. A following addi 001000 completes in 4 cycles via ADDIEX/ADDIWB.
- rst_n low during MEMRD of a lw → next state FETCH, no reg_write, retired unchanged. Also: CNT_W=4 with 16 j instructions → retired wraps to 0.
